wb_scheduler: RTL and testbench
===============================

// Module: wb_scheduler
//
// PURPOSE
// - Buffered writeback scheduler ahead of the single register-file/ROB write port.
// - Three producers (mem, ex, alu) each push completed results into a private FIFO via valid/ready.
// - Each cycle one FIFO head is chosen: fixed priority mem > ex > alu, with an aging override so ex/alu never starve.
// - The winner is registered onto the writeback port; replaces unbuffered allowed-wb back-pressure with queued completion.
//
// PARAMETERS
// - ROB_ENTRY_WIDTH  params_pkg::ROB_ENTRY_WIDTH  ROB index width
// - REGISTER_WIDTH   params_pkg::REGISTER_WIDTH   architectural register index width
// - DATA_WIDTH       params_pkg::DATA_WIDTH       result width
// - ADDR_WIDTH       params_pkg::ADDR_WIDTH       exception tval width
// - FIFO_DEPTH       4                            entries per source FIFO; power of 2, >=2
// - STARVE_LIMIT     8                            wait cycles before ex/alu head is force-granted; >=1
//
// PORTS  (<s> = mem, ex, alu; one set each)
// - clk_i                 in   1                core clock, all state on rising edge
// - rst_ni                in   1                asynchronous active-low reset
// - flush_i               in   1                synchronous pipeline flush
// - <s>_valid_i           in   1                producer has a completed result
// - <s>_ready_o           out  1                FIFO can accept this cycle
// - <s>_rob_idx_i         in   ROB_ENTRY_WIDTH  ROB slot of result
// - <s>_wr_reg_i          in   REGISTER_WIDTH   destination register
// - <s>_data_i            in   DATA_WIDTH       result data
// - <s>_reg_wr_en_i       in   1                result writes a register
// - mem_excpt_i           in   1                mem result carries an exception
// - mem_excpt_tval_i      in   ADDR_WIDTH       exception tval
// - mem_excpt_cause_i     in   excpt_cause_t    exception cause
// - wb_valid_o            out  1                writeback port valid, one cycle per result
// - wb_reg_wr_en_o        out  1                register-file write enable
// - wb_rob_idx_o          out  ROB_ENTRY_WIDTH  ROB slot completed/faulted
// - wb_wr_reg_o           out  REGISTER_WIDTH   destination register
// - wb_data_o             out  DATA_WIDTH       write data
// - wb_completed_o        out  1                ROB entry completed normally
// - wb_excpt_o            out  1                ROB entry completed with exception
// - wb_excpt_tval_o       out  ADDR_WIDTH       tval; zero when wb_excpt_o=0
// - wb_excpt_cause_o      out  excpt_cause_t    cause; all-zero when wb_excpt_o=0
//
// BEHAVIOUR
// - Reset (rst_ni=0, async): FIFOs empty, age counters 0, every output 0, <s>_ready_o=1 once released.
// - Enqueue: <s>_valid_i && <s>_ready_o at edge. <s>_ready_o = !full; no pass-through or replace when full, even if popping same cycle.
// - Pointers wrap modulo FIFO_DEPTH; full/empty via extra pointer MSB.
// - Arbitration (comb, on FIFO heads):
//   - If an ex/alu head has age >= STARVE_LIMIT, it wins; both starved -> larger age wins, tie -> ex.
//   - Otherwise mem > ex > alu.
//   - At most one pop per cycle.
// - Age: per ex/alu, +1 each cycle head is non-empty and not granted, saturating at STARVE_LIMIT; 0 on grant or when empty. mem has no age.
// - Output: winner popped; fields registered at same edge -> wb_valid_o high next cycle.
//   - Latency: accepted at edge N -> earliest wb_valid_o after edge N+1. Throughput 1/cycle.
// - Output encoding:
//   - Non-excepting: wb_completed_o=1, wb_reg_wr_en_o=<s>_reg_wr_en, tval/cause 0.
//   - mem exception: wb_excpt_o=1, wb_completed_o=0, wb_reg_wr_en_o=0, tval/cause forwarded.
// - No winner: wb_valid_o, wb_completed_o, wb_excpt_o, wb_reg_wr_en_o = 0; data fields hold 0.
// - flush_i: at edge, all FIFOs emptied, ages 0, output regs 0; concurrent enqueues dropped; no pop that cycle.
// - Reset mid-operation: in-flight entries discarded silently.
//
// CONFIGURATION
// - WB_SCHED_STATS_EN defined: adds outputs, 32-bit wrapping counters, cleared by reset only (not flush):
//   - stat_mem_grants_o, stat_ex_grants_o, stat_alu_grants_o: +1 per grant.
//   - stat_starve_grants_o: +1 per aging-override grant.
//   - stat_full_stall_o: +1 per cycle any <s>_valid_i with <s>_ready_o=0.
// - WB_SCHED_STATS_EN undefined: those ports and counters absent; behaviour otherwise identical.
//
// TESTING
// - Single alu push rob=3 reg=5 data=0xA5 wr_en=1 at edge 0 -> wb_valid_o=1, wb_completed_o=1, rob=3, reg=5, data=0xA5 in cycle after edge 1.
// - Same-edge mem/ex/alu pushes, rob 1/2/3 -> wb_rob_idx_o sequence 1,2,3 on three consecutive cycles.
// - mem valid every cycle, alu one push -> mem grants; alu wins after age reaches STARVE_LIMIT (8), then age returns to 0.
// - Fill ex FIFO with 4 entries, no pops -> ex_ready_o=0; 5th valid held until a pop; no entry lost or duplicated.
// - mem_excpt_i=1, tval=0x1000, cause set -> wb_excpt_o=1, wb_completed_o=0, wb_reg_wr_en_o=0, tval=0x1000.
// - Two entries queued, flush_i plus new alu push -> next cycle wb_valid_o=0, all ready=1, no writeback.
// - rst_ni low mid-queue -> all outputs 0 immediately, nothing output after release.

Source files
------------

// File: rtl/wb_scheduler.sv
// Buffered writeback scheduler: three result FIFOs, mem > ex > alu with aging override, one registered writeback per cycle.
// Latency: a result accepted at edge N appears on wb_* after edge N+1 at the earliest. Backpressure: <s>_ready_o = !full.
// Optional WB_SCHED_STATS_EN adds grant, starvation and stall counters (cleared by reset only).

module wb_sched_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] store [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr[PW-1:0]] <= wdata;
    end

    assign rdata = store[rd_ptr[PW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
endmodule

module wb_scheduler #(
    parameter int ROB_ENTRY_WIDTH = 5,
    parameter int REGISTER_WIDTH  = 5,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int CAUSE_WIDTH     = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       mem_valid_i,
    output logic                       mem_ready_o,
    input  logic [ROB_ENTRY_WIDTH-1:0] mem_rob_idx_i,
    input  logic [REGISTER_WIDTH-1:0]  mem_wr_reg_i,
    input  logic [DATA_WIDTH-1:0]      mem_data_i,
    input  logic                       mem_reg_wr_en_i,
    input  logic                       mem_excpt_i,
    input  logic [ADDR_WIDTH-1:0]      mem_excpt_tval_i,
    input  logic [CAUSE_WIDTH-1:0]     mem_excpt_cause_i,
    input  logic                       ex_valid_i,
    output logic                       ex_ready_o,
    input  logic [ROB_ENTRY_WIDTH-1:0] ex_rob_idx_i,
    input  logic [REGISTER_WIDTH-1:0]  ex_wr_reg_i,
    input  logic [DATA_WIDTH-1:0]      ex_data_i,
    input  logic                       ex_reg_wr_en_i,
    input  logic                       alu_valid_i,
    output logic                       alu_ready_o,
    input  logic [ROB_ENTRY_WIDTH-1:0] alu_rob_idx_i,
    input  logic [REGISTER_WIDTH-1:0]  alu_wr_reg_i,
    input  logic [DATA_WIDTH-1:0]      alu_data_i,
    input  logic                       alu_reg_wr_en_i,
    output logic                       wb_valid_o,
    output logic                       wb_reg_wr_en_o,
    output logic [ROB_ENTRY_WIDTH-1:0] wb_rob_idx_o,
    output logic [REGISTER_WIDTH-1:0]  wb_wr_reg_o,
    output logic [DATA_WIDTH-1:0]      wb_data_o,
    output logic                       wb_completed_o,
    output logic                       wb_excpt_o,
    output logic [ADDR_WIDTH-1:0]      wb_excpt_tval_o,
    output logic [CAUSE_WIDTH-1:0]     wb_excpt_cause_o
`ifdef WB_SCHED_STATS_EN
    ,
    output logic [31:0]                stat_mem_grants_o,
    output logic [31:0]                stat_ex_grants_o,
    output logic [31:0]                stat_alu_grants_o,
    output logic [31:0]                stat_starve_grants_o,
    output logic [31:0]                stat_full_stall_o
`endif
);
    localparam int ENT_W = ROB_ENTRY_WIDTH + REGISTER_WIDTH + DATA_WIDTH + 1;
    localparam int MEM_W = ENT_W + 1 + ADDR_WIDTH + CAUSE_WIDTH;
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] LIMIT = AGE_W'(STARVE_LIMIT);

    logic             mem_empty, mem_full, ex_empty, ex_full, alu_empty, alu_full;
    logic             mem_push, ex_push, alu_push;
    logic [MEM_W-1:0] mem_head;
    logic [ENT_W-1:0] ex_head, alu_head;
    logic [AGE_W-1:0] ex_age, alu_age;
    logic             ex_starved, alu_starved;
    logic             grant_mem, grant_ex, grant_alu, starve_grant, any_grant;

    logic [ROB_ENTRY_WIDTH-1:0] sel_rob;
    logic [REGISTER_WIDTH-1:0]  sel_reg;
    logic [DATA_WIDTH-1:0]      sel_data;
    logic                       sel_wen;
    logic                       sel_exc;
    logic [ADDR_WIDTH-1:0]      sel_tval;
    logic [CAUSE_WIDTH-1:0]     sel_cause;

    assign mem_ready_o = !mem_full;
    assign ex_ready_o  = !ex_full;
    assign alu_ready_o = !alu_full;

    // Flush drops same-cycle enqueues and suppresses the pop.
    assign mem_push = mem_valid_i && !mem_full && !flush_i;
    assign ex_push  = ex_valid_i  && !ex_full  && !flush_i;
    assign alu_push = alu_valid_i && !alu_full && !flush_i;

    wb_sched_fifo #(.W(MEM_W), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk(clk_i), .rst_n(rst_ni), .flush(flush_i),
        .push(mem_push), .pop(grant_mem && !flush_i),
        .wdata({mem_excpt_i, mem_excpt_tval_i, mem_excpt_cause_i,
                mem_rob_idx_i, mem_wr_reg_i, mem_data_i, mem_reg_wr_en_i}),
        .rdata(mem_head), .empty(mem_empty), .full(mem_full)
    );

    wb_sched_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_ex_fifo (
        .clk(clk_i), .rst_n(rst_ni), .flush(flush_i),
        .push(ex_push), .pop(grant_ex && !flush_i),
        .wdata({ex_rob_idx_i, ex_wr_reg_i, ex_data_i, ex_reg_wr_en_i}),
        .rdata(ex_head), .empty(ex_empty), .full(ex_full)
    );

    wb_sched_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk(clk_i), .rst_n(rst_ni), .flush(flush_i),
        .push(alu_push), .pop(grant_alu && !flush_i),
        .wdata({alu_rob_idx_i, alu_wr_reg_i, alu_data_i, alu_reg_wr_en_i}),
        .rdata(alu_head), .empty(alu_empty), .full(alu_full)
    );

    assign ex_starved  = !ex_empty  && (ex_age  >= LIMIT);
    assign alu_starved = !alu_empty && (alu_age >= LIMIT);

    always_comb begin
        grant_mem    = 1'b0;
        grant_ex     = 1'b0;
        grant_alu    = 1'b0;
        starve_grant = 1'b0;
        if (ex_starved && alu_starved) begin
            starve_grant = 1'b1;
            if (ex_age >= alu_age) grant_ex  = 1'b1;
            else                   grant_alu = 1'b1;
        end else if (ex_starved) begin
            starve_grant = 1'b1;
            grant_ex     = 1'b1;
        end else if (alu_starved) begin
            starve_grant = 1'b1;
            grant_alu    = 1'b1;
        end else if (!mem_empty) begin
            grant_mem = 1'b1;
        end else if (!ex_empty) begin
            grant_ex = 1'b1;
        end else if (!alu_empty) begin
            grant_alu = 1'b1;
        end
    end

    assign any_grant = grant_mem || grant_ex || grant_alu;

    always_comb begin
        sel_exc   = 1'b0;
        sel_tval  = '0;
        sel_cause = '0;
        {sel_rob, sel_reg, sel_data, sel_wen} = alu_head;
        if (grant_mem) begin
            {sel_exc, sel_tval, sel_cause, sel_rob, sel_reg, sel_data, sel_wen} = mem_head;
        end else if (grant_ex) begin
            {sel_rob, sel_reg, sel_data, sel_wen} = ex_head;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_age  <= '0;
            alu_age <= '0;
        end else if (flush_i) begin
            ex_age  <= '0;
            alu_age <= '0;
        end else begin
            if (ex_empty || grant_ex)   ex_age  <= '0;
            else if (ex_age != LIMIT)   ex_age  <= ex_age + 1'b1;
            if (alu_empty || grant_alu) alu_age <= '0;
            else if (alu_age != LIMIT)  alu_age <= alu_age + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_valid_o       <= 1'b0;
            wb_reg_wr_en_o   <= 1'b0;
            wb_rob_idx_o     <= '0;
            wb_wr_reg_o      <= '0;
            wb_data_o        <= '0;
            wb_completed_o   <= 1'b0;
            wb_excpt_o       <= 1'b0;
            wb_excpt_tval_o  <= '0;
            wb_excpt_cause_o <= '0;
        end else if (flush_i || !any_grant) begin
            wb_valid_o       <= 1'b0;
            wb_reg_wr_en_o   <= 1'b0;
            wb_rob_idx_o     <= '0;
            wb_wr_reg_o      <= '0;
            wb_data_o        <= '0;
            wb_completed_o   <= 1'b0;
            wb_excpt_o       <= 1'b0;
            wb_excpt_tval_o  <= '0;
            wb_excpt_cause_o <= '0;
        end else begin
            wb_valid_o       <= 1'b1;
            wb_reg_wr_en_o   <= sel_wen && !sel_exc;
            wb_rob_idx_o     <= sel_rob;
            wb_wr_reg_o      <= sel_reg;
            wb_data_o        <= sel_data;
            wb_completed_o   <= !sel_exc;
            wb_excpt_o       <= sel_exc;
            wb_excpt_tval_o  <= sel_exc ? sel_tval  : '0;
            wb_excpt_cause_o <= sel_exc ? sel_cause : '0;
        end
    end

`ifdef WB_SCHED_STATS_EN
    logic full_stall;
    assign full_stall = (mem_valid_i && mem_full) || (ex_valid_i && ex_full)
                     || (alu_valid_i && alu_full);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_mem_grants_o    <= '0;
            stat_ex_grants_o     <= '0;
            stat_alu_grants_o    <= '0;
            stat_starve_grants_o <= '0;
            stat_full_stall_o    <= '0;
        end else begin
            if (grant_mem && !flush_i)    stat_mem_grants_o    <= stat_mem_grants_o + 1'b1;
            if (grant_ex && !flush_i)     stat_ex_grants_o     <= stat_ex_grants_o + 1'b1;
            if (grant_alu && !flush_i)    stat_alu_grants_o    <= stat_alu_grants_o + 1'b1;
            if (starve_grant && !flush_i) stat_starve_grants_o <= stat_starve_grants_o + 1'b1;
            if (full_stall)               stat_full_stall_o    <= stat_full_stall_o + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_wb_scheduler.sv
// Bench for wb_scheduler: directed scenarios then random traffic, checked against a queue-based model.
module tb_wb_scheduler;
    localparam int RW = 5, GW = 5, DW = 32, AW = 32, CW = 4, DEPTH = 4, LIM = 8;

    logic clk = 1'b0;
    logic rst_n, flush;
    logic mem_valid, mem_ready, mem_wen, mem_exc;
    logic ex_valid, ex_ready, ex_wen, alu_valid, alu_ready, alu_wen;
    logic [RW-1:0] mem_rob, ex_rob, alu_rob, wb_rob;
    logic [GW-1:0] mem_reg, ex_reg, alu_reg, wb_reg;
    logic [DW-1:0] mem_data, ex_data, alu_data, wb_data;
    logic [AW-1:0] mem_tval, wb_tval;
    logic [CW-1:0] mem_cause, wb_cause;
    logic wb_valid, wb_wen, wb_completed, wb_excpt;

    always #5 clk = ~clk;

    wb_scheduler dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .mem_valid_i(mem_valid), .mem_ready_o(mem_ready), .mem_rob_idx_i(mem_rob),
        .mem_wr_reg_i(mem_reg), .mem_data_i(mem_data), .mem_reg_wr_en_i(mem_wen),
        .mem_excpt_i(mem_exc), .mem_excpt_tval_i(mem_tval), .mem_excpt_cause_i(mem_cause),
        .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_rob_idx_i(ex_rob),
        .ex_wr_reg_i(ex_reg), .ex_data_i(ex_data), .ex_reg_wr_en_i(ex_wen),
        .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_rob_idx_i(alu_rob),
        .alu_wr_reg_i(alu_reg), .alu_data_i(alu_data), .alu_reg_wr_en_i(alu_wen),
        .wb_valid_o(wb_valid), .wb_reg_wr_en_o(wb_wen), .wb_rob_idx_o(wb_rob),
        .wb_wr_reg_o(wb_reg), .wb_data_o(wb_data), .wb_completed_o(wb_completed),
        .wb_excpt_o(wb_excpt), .wb_excpt_tval_o(wb_tval), .wb_excpt_cause_o(wb_cause)
    );

    typedef struct {
        logic [RW-1:0] rob;
        logic [GW-1:0] rg;
        logic [DW-1:0] data;
        logic          wen;
        logic          exc;
        logic [AW-1:0] tval;
        logic [CW-1:0] cause;
    } ent_t;

    ent_t mq[$], eq[$], aq[$];
    int ex_age = 0, alu_age = 0;
    int n_cmp = 0, n_bad = 0;
    int found_at;
    bit accepted;

    logic [81:0] obs;
    assign obs = {wb_valid, wb_wen, wb_rob, wb_reg, wb_data, wb_completed, wb_excpt, wb_tval, wb_cause};

    task automatic chk(input string tag, input logic [81:0] got, input logic [81:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    function automatic logic [81:0] encode(input ent_t e);
        if (e.exc) return {1'b1, 1'b0, e.rob, e.rg, e.data, 1'b0, 1'b1, e.tval, e.cause};
        return {1'b1, e.wen, e.rob, e.rg, e.data, 1'b1, 1'b0, {AW{1'b0}}, {CW{1'b0}}};
    endfunction

    task automatic idle();
        flush = 0; mem_valid = 0; ex_valid = 0; alu_valid = 0;
        mem_exc = 0; mem_tval = '0; mem_cause = '0;
    endtask

    task automatic put(input int s, input logic [RW-1:0] rob, input logic [GW-1:0] rg,
                       input logic [DW-1:0] d, input logic wen);
        case (s)
            0: begin mem_valid = 1; mem_rob = rob; mem_reg = rg; mem_data = d; mem_wen = wen; end
            1: begin ex_valid  = 1; ex_rob  = rob; ex_reg  = rg; ex_data  = d; ex_wen  = wen; end
            default: begin alu_valid = 1; alu_rob = rob; alu_reg = rg; alu_data = d; alu_wen = wen; end
        endcase
    endtask

    // One clock: check ready before the edge, advance the model, check writeback after it.
    task automatic tick(input string tag);
        logic [2:0] rdy;
        logic [81:0] expv;
        int win;
        ent_t e;
        bit es, as;
        rdy = {mq.size() < DEPTH, eq.size() < DEPTH, aq.size() < DEPTH};
        chk({tag, "_ready"}, {79'd0, mem_ready, ex_ready, alu_ready}, {79'd0, rdy});
        expv = '0;
        if (flush) begin
            mq.delete(); eq.delete(); aq.delete();
            ex_age = 0; alu_age = 0;
        end else begin
            es = eq.size() > 0 && ex_age >= LIM;
            as = aq.size() > 0 && alu_age >= LIM;
            if (es && as)             win = (ex_age >= alu_age) ? 1 : 2;
            else if (es)              win = 1;
            else if (as)              win = 2;
            else if (mq.size() > 0)   win = 0;
            else if (eq.size() > 0)   win = 1;
            else if (aq.size() > 0)   win = 2;
            else                      win = -1;
            ex_age  = (eq.size() == 0 || win == 1) ? 0 : (ex_age  < LIM ? ex_age + 1  : LIM);
            alu_age = (aq.size() == 0 || win == 2) ? 0 : (alu_age < LIM ? alu_age + 1 : LIM);
            if (win == 0) begin e = mq.pop_front(); expv = encode(e); end
            if (win == 1) begin e = eq.pop_front(); expv = encode(e); end
            if (win == 2) begin e = aq.pop_front(); expv = encode(e); end
            if (mem_valid && rdy[2]) mq.push_back('{mem_rob, mem_reg, mem_data, mem_wen, mem_exc, mem_tval, mem_cause});
            if (ex_valid && rdy[1])  eq.push_back('{ex_rob, ex_reg, ex_data, ex_wen, 1'b0, '0, '0});
            if (alu_valid && rdy[0]) aq.push_back('{alu_rob, alu_reg, alu_data, alu_wen, 1'b0, '0, '0});
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_wb"}, obs, expv);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            tick("drain");
        end
    endtask

    initial begin
        rst_n = 0;
        mem_rob = '0; mem_reg = '0; mem_data = '0; mem_wen = 0;
        ex_rob = '0; ex_reg = '0; ex_data = '0; ex_wen = 0;
        alu_rob = '0; alu_reg = '0; alu_data = '0; alu_wen = 0;
        idle();
        #2;
        chk("reset_out", obs, '0);
        chk("reset_ready", {79'd0, mem_ready, ex_ready, alu_ready}, 82'd7);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        // Single alu result
        idle(); put(2, 5'd3, 5'd5, 32'hA5, 1'b1); tick("alu_push");
        idle(); tick("alu_out");
        chk("alu_fields", {wb_valid, wb_completed, wb_wen, 5'(wb_rob), 5'(wb_reg), wb_data},
            {1'b1, 1'b1, 1'b1, 5'd3, 5'd5, 32'hA5});

        // Same-edge pushes from all three sources
        idle(); put(0, 5'd1, 5'd7, 32'h11, 1'b1); put(1, 5'd2, 5'd8, 32'h22, 1'b1);
        put(2, 5'd3, 5'd9, 32'h33, 1'b0); tick("tri_push");
        idle(); tick("tri_1"); chk("tri_rob1", {wb_valid, wb_rob}, {1'b1, 5'd1});
        idle(); tick("tri_2"); chk("tri_rob2", {wb_valid, wb_rob}, {1'b1, 5'd2});
        idle(); tick("tri_3"); chk("tri_rob3", {wb_valid, wb_rob}, {1'b1, 5'd3});

        // Continuous mem traffic must not starve a single alu result
        found_at = -1;
        for (int i = 0; i < 12; i++) begin
            idle();
            put(0, 5'(i + 1), 5'd1, 32'(i), 1'b1);
            if (i == 0) put(2, 5'd20, 5'd2, 32'hBEEF, 1'b1);
            tick("starve");
            if (wb_valid && wb_rob == 5'd20 && found_at < 0) found_at = i;
        end
        chk("starve_cycle", 82'(found_at), 82'd9);
        drain(4);

        // Fill ex FIFO behind mem traffic, then hold a fifth result until it fits
        for (int i = 0; i < 4; i++) begin
            idle(); put(0, 5'(i), 5'd3, 32'(i), 1'b1); put(1, 5'(10 + i), 5'd4, 32'(100 + i), 1'b1);
            tick("fill");
        end
        chk("ex_full_ready", {81'd0, ex_ready}, 82'd0);
        accepted = 0;
        for (int i = 0; i < 30 && !accepted; i++) begin
            idle(); put(0, 5'(i), 5'd3, 32'(i), 1'b1); put(1, 5'd9, 5'd4, 32'h999, 1'b1);
            accepted = eq.size() < DEPTH;
            tick("hold5");
        end
        chk("ex5_accepted", {81'd0, accepted}, 82'd1);
        drain(10);

        // mem exception
        idle(); put(0, 5'd7, 5'd6, 32'h77, 1'b1);
        mem_exc = 1; mem_tval = 32'h1000; mem_cause = 4'd5; tick("exc_push");
        idle(); tick("exc_out");
        chk("exc_fields", {wb_valid, wb_excpt, wb_completed, wb_wen, wb_tval, wb_cause},
            {1'b1, 1'b1, 1'b0, 1'b0, 32'h1000, 4'd5});

        // Flush with queued entries and a concurrent push
        idle(); put(1, 5'd4, 5'd1, 32'h4, 1'b1); put(2, 5'd6, 5'd2, 32'h6, 1'b1); tick("pre_flush");
        idle(); flush = 1; put(2, 5'd8, 5'd3, 32'h8, 1'b1); tick("flush");
        chk("flush_valid", {81'd0, wb_valid}, 82'd0);
        idle(); tick("post_flush");
        chk("post_flush_quiet", {79'd0, wb_valid, ex_ready, alu_ready}, 82'd3);

        // Reset while results are queued
        idle(); put(0, 5'd1, 5'd1, 32'h1, 1'b1); put(1, 5'd2, 5'd2, 32'h2, 1'b1);
        put(2, 5'd3, 5'd3, 32'h3, 1'b1); tick("rst_fill");
        idle(); tick("rst_pop");
        rst_n = 0;
        #1;
        chk("rst_mid_out", obs, '0);
        mq.delete(); eq.delete(); aq.delete(); ex_age = 0; alu_age = 0;
        #1 rst_n = 1;
        drain(3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            idle();
            if ($urandom_range(0, 1) == 1) begin
                put(0, 5'($urandom), 5'($urandom), $urandom, 1'($urandom));
                if ($urandom_range(0, 3) == 0) begin
                    mem_exc = 1; mem_tval = $urandom; mem_cause = 4'($urandom);
                end
            end
            if ($urandom_range(0, 1) == 1) put(1, 5'($urandom), 5'($urandom), $urandom, 1'($urandom));
            if ($urandom_range(0, 1) == 1) put(2, 5'($urandom), 5'($urandom), $urandom, 1'($urandom));
            if ($urandom_range(0, 39) == 0) flush = 1;
            tick("rand");
        end
        drain(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
